// File: rtl/ex_mem_elastic.sv
// Elastic EX->MEM pipeline register: main slot plus one skid slot, registered ex_ready, sync flush.
// Optional hi/lo payload is enabled by defining EX_MEM_HILO_EN.
module ex_mem_elastic #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NOP_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [ADDR_W-1:0] ex_wd,
   input  logic              ex_wreg,
   input  logic [DATA_W-1:0] ex_wdata,
`ifdef EX_MEM_HILO_EN
   input  logic              ex_whilo,
   input  logic [DATA_W-1:0] ex_hi,
   input  logic [DATA_W-1:0] ex_lo,
   output logic              mem_whilo,
   output logic [DATA_W-1:0] mem_hi,
   output logic [DATA_W-1:0] mem_lo,
`endif
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_wd,
   output logic              mem_wreg,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [1:0]        occ
);

`ifdef EX_MEM_HILO_EN
   localparam int HILO_W = 2 * DATA_W + 1;
`else
   localparam int HILO_W = 0;
`endif
   localparam int PAY_W = ADDR_W + 1 + DATA_W + HILO_W;

   // Payload layout, MSB first: {wd, wreg, wdata[, whilo, hi, lo]}
   localparam logic [ADDR_W-1:0] NOP_WD = ADDR_W'(NOP_ADDR);
   localparam logic [PAY_W-1:0]  BUBBLE = {NOP_WD, {(PAY_W - ADDR_W){1'b0}}};

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [PAY_W-1:0] main_reg, main_next;
   logic [PAY_W-1:0] skid_reg, skid_next;
   logic             ready_reg, ready_next;
   logic [PAY_W-1:0] ex_pay;
   logic             in_fire;
   logic             out_fire;

`ifdef EX_MEM_HILO_EN
   assign ex_pay = {ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo};
`else
   assign ex_pay = {ex_wd, ex_wreg, ex_wdata};
`endif

   assign in_fire  = ex_valid & ready_reg;
   assign out_fire = (state_reg != EMPTY) & mem_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= EMPTY;
         main_reg  <= BUBBLE;
         skid_reg  <= '0;
         ready_reg <= 1'b1;
      end else begin
         state_reg <= state_next;
         main_reg  <= main_next;
         skid_reg  <= skid_next;
         ready_reg <= ready_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      main_next  = main_reg;
      skid_next  = skid_reg;
      unique case (state_reg)
         EMPTY: begin
            if (in_fire) begin
               main_next  = ex_pay;
               state_next = ONE;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               main_next = ex_pay;
            end else if (in_fire) begin
               skid_next  = ex_pay;
               state_next = TWO;
            end else if (out_fire) begin
               main_next  = BUBBLE;
               state_next = EMPTY;
            end
         end
         TWO: begin
            // ex_ready is low here, so only the drain path exists
            if (out_fire) begin
               main_next  = skid_reg;
               skid_next  = '0;
               state_next = ONE;
            end
         end
         default: begin
            main_next  = BUBBLE;
            skid_next  = '0;
            state_next = EMPTY;
         end
      endcase
      if (flush) begin
         main_next  = BUBBLE;
         skid_next  = '0;
         state_next = EMPTY;
      end
      // Registered from the next state so ex_ready never depends on mem_ready combinationally
      ready_next = (state_next != TWO);
   end

   assign ex_ready  = ready_reg;
   assign mem_valid = (state_reg != EMPTY);
   assign occ       = state_reg;
   assign mem_wd    = main_reg[PAY_W-1 -: ADDR_W];
   assign mem_wreg  = main_reg[PAY_W-ADDR_W-1];
   assign mem_wdata = main_reg[PAY_W-ADDR_W-2 -: DATA_W];
`ifdef EX_MEM_HILO_EN
   assign mem_whilo = main_reg[2*DATA_W];
   assign mem_hi    = main_reg[2*DATA_W-1 -: DATA_W];
   assign mem_lo    = main_reg[DATA_W-1:0];
`endif

endmodule

// File: tb/tb_ex_mem_elastic.sv
// Scoreboard bench for ex_mem_elastic: the driver queues expected entries on acceptance,
// an independent monitor pops and compares on every MEM-side transfer.
module tb_ex_mem_elastic;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        ex_valid;
   logic        ex_ready;
   logic [4:0]  ex_wd;
   logic        ex_wreg;
   logic [31:0] ex_wdata;
`ifdef EX_MEM_HILO_EN
   logic        ex_whilo;
   logic [31:0] ex_hi;
   logic [31:0] ex_lo;
   logic        mem_whilo;
   logic [31:0] mem_hi;
   logic [31:0] mem_lo;
`endif
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata;
   logic [1:0]  occ;

   typedef struct {
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      logic        whilo;
      logic [31:0] hi;
      logic [31:0] lo;
   } item_t;

   item_t sb[$];
   int    tests = 0;
   int    fails = 0;

   ex_mem_elastic #(.DATA_W(32), .ADDR_W(5), .NOP_ADDR(0)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .ex_valid  (ex_valid),
      .ex_ready  (ex_ready),
      .ex_wd     (ex_wd),
      .ex_wreg   (ex_wreg),
      .ex_wdata  (ex_wdata),
`ifdef EX_MEM_HILO_EN
      .ex_whilo  (ex_whilo),
      .ex_hi     (ex_hi),
      .ex_lo     (ex_lo),
      .mem_whilo (mem_whilo),
      .mem_hi    (mem_hi),
      .mem_lo    (mem_lo),
`endif
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_wd    (mem_wd),
      .mem_wreg  (mem_wreg),
      .mem_wdata (mem_wdata),
      .occ       (occ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end else begin
         $display("[TB] ok   %s = 0x%0h", name, got);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Presents one entry and waits (bounded) for the edge that accepts it.
   task automatic send(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                       input logic whilo, input logic [31:0] hi, input logic [31:0] lo);
      item_t it;
      bit    done;
      done     = 1'b0;
      ex_valid = 1'b1;
      ex_wd    = wd;
      ex_wreg  = wreg;
      ex_wdata = wdata;
`ifdef EX_MEM_HILO_EN
      ex_whilo = whilo;
      ex_hi    = hi;
      ex_lo    = lo;
`endif
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (ex_ready && !flush && !rst) begin
            @(posedge clk);
            it.wd    = wd;
            it.wreg  = wreg;
            it.wdata = wdata;
            it.whilo = whilo;
            it.hi    = hi;
            it.lo    = lo;
            sb.push_back(it);
            done = 1'b1;
            $display("[TB] in   wd=%0d wreg=%0b wdata=0x%0h", wd, wreg, wdata);
         end else begin
            @(posedge clk);
         end
      end
      #1;
      ex_valid = 1'b0;
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: wd=%0d got no acceptance, expected acceptance", wd);
      end
   endtask

   // Monitor: an out transfer happens at the next posedge when mem_valid & mem_ready here.
   always @(negedge clk) begin : monitor
      item_t e;
      if (rst) begin
         sb.delete();
      end else begin
         if (mem_valid && mem_ready) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_out: got wd=%0d wdata=0x%0h, expected no entry",
                        mem_wd, mem_wdata);
            end else begin
               e = sb.pop_front();
               $display("[TB] out  wd=%0d wreg=%0b wdata=0x%0h", mem_wd, mem_wreg, mem_wdata);
               chk("out_wd", 32'(mem_wd), 32'(e.wd));
               chk("out_wreg", 32'(mem_wreg), 32'(e.wreg));
               chk("out_wdata", mem_wdata, e.wdata);
`ifdef EX_MEM_HILO_EN
               chk("out_whilo", 32'(mem_whilo), 32'(e.whilo));
               chk("out_hi", mem_hi, e.hi);
               chk("out_lo", mem_lo, e.lo);
`endif
            end
         end else if (!mem_valid) begin
            chk("bubble_wd", 32'(mem_wd), 32'd0);
            chk("bubble_wreg", 32'(mem_wreg), 32'd0);
            chk("bubble_wdata", mem_wdata, 32'd0);
`ifdef EX_MEM_HILO_EN
            chk("bubble_whilo", 32'(mem_whilo), 32'd0);
            chk("bubble_hilo", mem_hi | mem_lo, 32'd0);
`endif
         end
         if (flush) sb.delete();
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      rst       = 1'b1;
      flush     = 1'b0;
      ex_valid  = 1'b0;
      ex_wd     = '0;
      ex_wreg   = 1'b0;
      ex_wdata  = '0;
`ifdef EX_MEM_HILO_EN
      ex_whilo  = 1'b0;
      ex_hi     = '0;
      ex_lo     = '0;
`endif
      mem_ready = 1'b0;

      cyc(2);
      chk("rst_valid", 32'(mem_valid), 32'd0);
      chk("rst_occ", 32'(occ), 32'd0);
      chk("rst_ready", 32'(ex_ready), 32'd1);
      chk("rst_wd", 32'(mem_wd), 32'd0);
      rst = 1'b0;
      cyc(1);

      // Back-to-back streaming with MEM always ready
      mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(5'(i + 1), 1'b1, 32'h0A0 + 32'(i), 1'b0, 32'd0, 32'd0);
         chk("t2_valid", 32'(mem_valid), 32'd1);
         chk("t2_wd", 32'(mem_wd), 32'(i + 1));
         chk("t2_ready", 32'(ex_ready), 32'd1);
      end
      cyc(2);
      chk("t2_occ_drained", 32'(occ), 32'd0);

      // Backpressure fills the skid, extra entry held off, then drains in order
      mem_ready = 1'b0;
      send(5'd5, 1'b1, 32'h0B5, 1'b0, 32'd0, 32'd0);
      send(5'd6, 1'b0, 32'h0B6, 1'b0, 32'd0, 32'd0);
      chk("t3_occ_full", 32'(occ), 32'd2);
      chk("t3_ready_low", 32'(ex_ready), 32'd0);
      ex_valid = 1'b1;
      ex_wd    = 5'd7;
      ex_wdata = 32'h0B7;
      cyc(2);
      chk("t3_occ_held", 32'(occ), 32'd2);
      chk("t3_head_wd", 32'(mem_wd), 32'd5);
      ex_valid  = 1'b0;
      mem_ready = 1'b1;
      send(5'd7, 1'b1, 32'h0B7, 1'b0, 32'd0, 32'd0);
      cyc(4);
      chk("t3_occ_drained", 32'(occ), 32'd0);
      chk("t3_sb_empty", 32'(sb.size()), 32'd0);

      // Flush while full, with a competing incoming entry
      mem_ready = 1'b0;
      send(5'd8, 1'b1, 32'h0C8, 1'b0, 32'd0, 32'd0);
      send(5'd10, 1'b1, 32'h0CA, 1'b0, 32'd0, 32'd0);
      chk("t4_occ_full", 32'(occ), 32'd2);
      flush    = 1'b1;
      ex_valid = 1'b1;
      ex_wd    = 5'd9;
      ex_wdata = 32'h0C9;
      cyc(1);
      flush    = 1'b0;
      ex_valid = 1'b0;
      chk("t4_occ", 32'(occ), 32'd0);
      chk("t4_valid", 32'(mem_valid), 32'd0);
      chk("t4_wd", 32'(mem_wd), 32'd0);
      chk("t4_ready", 32'(ex_ready), 32'd1);
      mem_ready = 1'b1;
      cyc(3);

      // Simultaneous in and out while holding one entry
      mem_ready = 1'b0;
      send(5'd3, 1'b1, 32'h0D3, 1'b0, 32'd0, 32'd0);
      chk("t5_occ_one", 32'(occ), 32'd1);
      mem_ready = 1'b1;
      send(5'd4, 1'b0, 32'h0D4, 1'b0, 32'd0, 32'd0);
      chk("t5_wd", 32'(mem_wd), 32'd4);
      chk("t5_wdata", mem_wdata, 32'h0D4);
      chk("t5_occ", 32'(occ), 32'd1);
      cyc(3);
      chk("t5_sb_empty", 32'(sb.size()), 32'd0);

      // Asynchronous reset mid-stream with the skid full
      mem_ready = 1'b0;
      send(5'd11, 1'b1, 32'h0E1, 1'b0, 32'd0, 32'd0);
      send(5'd12, 1'b1, 32'h0E2, 1'b0, 32'd0, 32'd0);
      chk("t1_occ_full", 32'(occ), 32'd2);
      #2;
      rst = 1'b1;
      #1;
      chk("t1_valid", 32'(mem_valid), 32'd0);
      chk("t1_wreg", 32'(mem_wreg), 32'd0);
      chk("t1_wd", 32'(mem_wd), 32'd0);
      chk("t1_occ", 32'(occ), 32'd0);
      cyc(1);
      rst = 1'b0;
      cyc(1);
      chk("t1_ready", 32'(ex_ready), 32'd1);
      chk("t1_occ_after", 32'(occ), 32'd0);

      // hi/lo payload through a stall (port checks only when present)
      mem_ready = 1'b0;
      send(5'd2, 1'b1, 32'h0F0, 1'b1, 32'hDEAD, 32'hBEEF);
      send(5'd13, 1'b1, 32'h0F1, 1'b0, 32'h1111, 32'h2222);
      chk("t6_occ_full", 32'(occ), 32'd2);
`ifdef EX_MEM_HILO_EN
      chk("t6_whilo", 32'(mem_whilo), 32'd1);
      chk("t6_hi", mem_hi, 32'hDEAD);
      chk("t6_lo", mem_lo, 32'hBEEF);
`endif
      cyc(2);
      mem_ready = 1'b1;
      cyc(4);
      chk("t6_occ_drained", 32'(occ), 32'd0);
`ifdef EX_MEM_HILO_EN
      chk("t6_whilo_idle", 32'(mem_whilo), 32'd0);
`endif

      cyc(2);
      chk("final_sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
